// File: rtl/pipelined_parallel_adder_if.sv
// Operand/result stream bundle for pipelined_parallel_adder.
// Optional ovf signal present only when PPA_OVF_EN is defined.
interface pipelined_parallel_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PPA_OVF_EN
  logic             ovf;

  // producer/consumer side
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  // adder side
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  // producer/consumer side
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  // adder side
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_parallel_adder.sv
// Pipelined chunked adder: WIDTH-bit a + b + cin over STAGES stages, one
// CHUNK = WIDTH/STAGES slice per stage, carry handed stage to stage.
// Valid/ready on both sides, bubbles collapse, no skid buffer.
// Optional macro PPA_OVF_EN adds the signed-overflow output ovf and the
// sign-bit registers that travel with each beat.
// WIDTH must be an exact multiple of STAGES (1 <= STAGES <= WIDTH).

// CHUNK-bit ripple of full adders
module ppa_chunk_add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic cy;

  // ripple the carry bit by bit through the slice
  always_comb begin
    s  = '0;
    cy = ci;
    for (int i = 0; i < N; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end
endmodule

module pipelined_parallel_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_parallel_adder_if.slave ifc
);
  localparam int CHUNK = WIDTH / STAGES;

  // vld_pipe[0] is the incoming beat, vld_pipe[k+1] is stage k occupancy
  logic [STAGES:0]             vld_pipe;
  // rdy[k]: stage k may load this cycle; rdy[STAGES] is the consumer
  logic [STAGES:0]             rdy;
  // stage k: sum chunks 0..k below, untouched a chunks above
  logic [STAGES-1:0][WIDTH-1:0] acc_q;
  logic [STAGES-1:0]           cy_q;
`ifdef PPA_OVF_EN
  logic [STAGES-1:0]           sa_q;
  logic [STAGES-1:0]           sb_q;
`endif

  assign vld_pipe[0] = ifc.in_valid;
  assign rdy[STAGES] = ifc.out_ready;
  assign ifc.in_ready  = rdy[0];
  assign ifc.out_valid = vld_pipe[STAGES];
  assign ifc.sum       = acc_q[STAGES-1];
  assign ifc.cout      = cy_q[STAGES-1];
`ifdef PPA_OVF_EN
  assign ifc.ovf = (sa_q[STAGES-1] == sb_q[STAGES-1]) &&
                   (acc_q[STAGES-1][WIDTH-1] != sa_q[STAGES-1]);
`endif

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO  = k * CHUNK;
    // b bits still pending on entry to this stage (chunk k and above)
    localparam int BIN = WIDTH - LO;

    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] acc_r;
    logic [BIN-1:0]   b_in;
    logic [CHUNK-1:0] s_chunk;
    logic             c_in;
    logic             c_out;
    logic             cy_r;
    logic             v_r;
    logic             ld;
`ifdef PPA_OVF_EN
    logic             sa_in;
    logic             sb_in;
    logic             sa_r;
    logic             sb_r;
`endif

    if (k == 0) begin : g_src
      assign acc_in = ifc.a;
      assign b_in   = ifc.b;
      assign c_in   = ifc.cin;
`ifdef PPA_OVF_EN
      assign sa_in  = ifc.a[WIDTH-1];
      assign sb_in  = ifc.b[WIDTH-1];
`endif
    end else begin : g_src
      assign acc_in = acc_q[k-1];
      assign b_in   = stg[k-1].g_bq.b_q;
      assign c_in   = cy_q[k-1];
`ifdef PPA_OVF_EN
      assign sa_in  = sa_q[k-1];
      assign sb_in  = sb_q[k-1];
`endif
    end

    assign rdy[k]        = !v_r || rdy[k+1];
    assign vld_pipe[k+1] = v_r;
    // load only real beats; an empty upstream just clears v_r (bubble)
    assign ld            = rdy[k] && vld_pipe[k];
    assign acc_q[k]      = acc_r;
    assign cy_q[k]       = cy_r;
`ifdef PPA_OVF_EN
    assign sa_q[k]       = sa_r;
    assign sb_q[k]       = sb_r;
`endif

    ppa_chunk_add #(.N(CHUNK)) u_add (
      .a  (acc_in[LO +: CHUNK]),
      .b  (b_in[CHUNK-1:0]),
      .ci (c_in),
      .s  (s_chunk),
      .co (c_out)
    );

    // splice the freshly resolved chunk into the accumulator
    always_comb begin
      acc_nxt              = acc_in;
      acc_nxt[LO +: CHUNK] = s_chunk;
    end

    // stage occupancy: follows upstream whenever this stage may move
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      v_r <= 1'b0;
      else if (rdy[k]) v_r <= vld_pipe[k];
    end

    // stage data: partial sum, outgoing carry (and sign bits)
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_r <= '0;
        cy_r  <= 1'b0;
`ifdef PPA_OVF_EN
        sa_r  <= 1'b0;
        sb_r  <= 1'b0;
`endif
      end else if (ld) begin
        acc_r <= acc_nxt;
        cy_r  <= c_out;
`ifdef PPA_OVF_EN
        sa_r  <= sa_in;
        sb_r  <= sb_in;
`endif
      end
    end

    // pending b chunks shrink by one chunk per stage; none after the last
    if (k < STAGES - 1) begin : g_bq
      logic [BIN-CHUNK-1:0] b_q;

      // carry the unconsumed b chunks forward with the beat
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  b_q <= '0;
        else if (ld) b_q <= b_in[BIN-1:CHUNK];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// Scoreboard bench for pipelined_parallel_adder (WIDTH=16, STAGES=4).
// Expected results come from plain a+b+cin arithmetic; a monitor pops them
// as the DUT hands results out. Honors PPA_OVF_EN like the design.
module tb_pipelined_parallel_adder;
  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  bit   chk_lat;
  exp_t q[$];

  pipelined_parallel_adder_if #(.WIDTH(W)) ifc ();

  pipelined_parallel_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifc   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: full-precision add plus signed overflow rule
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    e.cyc  = 0;
    e.lat  = 0;
    return e;
  endfunction

  // scoreboard: push on accept, pop/compare on consume, hold-check on stall
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ifc.in_valid && ifc.in_ready) begin
        e     = model(ifc.a, ifc.b, ifc.cin);
        e.cyc = cyc;
        e.lat = chk_lat;
        q.push_back(e);
      end
      if (ifc.out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out actual sum=%0h with no beat outstanding (cycle %0d)", ifc.sum, cyc);
        end else if (ifc.out_ready) begin
          e = q.pop_front();
          chk("sum_cout", {47'd0, ifc.cout, ifc.sum}, {47'd0, e.cout, e.sum});
`ifdef PPA_OVF_EN
          chk("ovf", {63'd0, ifc.ovf}, {63'd0, e.ovf});
`endif
          if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(S));
        end else begin
          chk("hold_sum", {47'd0, ifc.cout, ifc.sum}, {47'd0, q[0].cout, q[0].sum});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    int t;
    bit f;
    t = 0;
    f = 0;
    ifc.in_valid = 1'b1;
    ifc.a = av;
    ifc.b = bv;
    ifc.cin = cv;
    while (!f && t < 200) begin
      @(negedge clk);
      f = ifc.in_ready;
      tick();
      t++;
    end
    ifc.in_valid = 1'b0;
    if (!f) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout actual in_ready=0 required=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic rnd_beat();
    ifc.a   = W'($urandom);
    ifc.b   = W'($urandom);
    ifc.cin = 1'($urandom);
  endtask

  initial begin
    int  nacc;
    bit  f;
    bit  hold;
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vc [5];
    va = '{16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF, 16'hAAAA};
    vb = '{16'hFFFF, 16'h8000, 16'h0000, 16'h0001, 16'h5555};
    vc = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    cyc = 0; n_cmp = 0; n_err = 0; chk_lat = 0;
    ifc.in_valid = 0; ifc.a = 0; ifc.b = 0; ifc.cin = 0; ifc.out_ready = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_sum", {48'd0, ifc.sum}, 64'd0);
    chk("rst_cout", {63'd0, ifc.cout}, 64'd0);
`ifdef PPA_OVF_EN
    chk("rst_ovf", {63'd0, ifc.ovf}, 64'd0);
`endif
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);

    // single beat, full carry out; latency checked by the scoreboard
    ifc.out_ready = 1'b1;
    chk_lat = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0);
    drain();

    // carry rippling through every chunk
    send(16'h7FFF, 16'h0000, 1'b1);
    drain();

    // corner vectors then 100 back-to-back random beats
    for (int i = 0; i < 5; i++) send(va[i], vb[i], vc[i]);
    for (int i = 0; i < 100; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    drain();
    chk_lat = 1'b0;

    // backpressure: only S beats fit while the consumer stalls
    ifc.out_ready = 1'b0;
    nacc = 0;
    ifc.in_valid = 1'b1;
    rnd_beat();
    repeat (10) begin
      @(negedge clk);
      f = ifc.in_ready;
      if (f) nacc++;
      tick();
      if (f) rnd_beat();
    end
    chk("bp_accepted", 64'(nacc), 64'(S));
    chk("bp_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, ifc.out_valid}, 64'd1);
    ifc.out_ready = 1'b1;
    send(ifc.a, ifc.b, ifc.cin);
    send(W'($urandom), W'($urandom), 1'($urandom));
    drain();

    // random valid and random backpressure
    hold = 0;
    repeat (300) begin
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        ifc.in_valid = 1'($urandom);
        rnd_beat();
      end
      @(negedge clk);
      hold = ifc.in_valid && !ifc.in_ready;
      tick();
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    drain();

    // reset with three beats in flight: none may ever emerge
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    repeat (3) tick();
    chk("mid_pre_valid", {63'd0, ifc.out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    q.delete();
    #1 chk("mid_rst_valid", {63'd0, ifc.out_valid}, 64'd0);
    tick();
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (12) tick();
    chk("mid_after_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("mid_after_sum", {48'd0, ifc.sum}, 64'd0);

    // pipe still works after the flush
    chk_lat = 1'b1;
    send(16'h1234, 16'h4321, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
